// File: rtl/usb_pkg.sv
// usb_pkg: USB constants shared by the EP0 sender, packetizer and request decoder
package usb_pkg;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam int EP0_MAXPKT = 64;
  typedef enum logic [2:0] {IDLE, WAIT_IN, RD, WR, SEND, WAIT_ACK, DONE} ep0_state_e;
endpackage

// File: rtl/usb_ep0_in_tx.sv
// usb_ep0_in_tx: EP0 IN data stage, streams a descriptor ROM window into the TX FIFO as DATA1/DATA0 chunks
module usb_ep0_in_tx
  import usb_pkg::*;
#(
  parameter int MAXPKT = EP0_MAXPKT,
  parameter int ROM_AW = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              setup_done,
  input  logic [ROM_AW-1:0] romaddr,
  input  logic [7:0]        romnum,
  input  logic              in_token,
  input  logic              ack_rcvd,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              push_tx,
  output logic [7:0]        datai_tx,
  input  logic              full_tx,
  output logic              tx_start,
  output logic [3:0]        tx_pid,
  output logic [6:0]        tx_len,
  output logic              busy,
  output logic              done
);
  localparam logic [6:0] MAXLEN = 7'(MAXPKT);
  ep0_state_e state_q, state_d;
  logic [ROM_AW-1:0] base_q, base_d, rom_addr_q, rom_addr_d;
  logic [7:0] rem_q, rem_d;
  logic [6:0] cnt_q, cnt_d, len_q, len_d, len;
  logic [3:0] pid_q, pid_d;
  logic tog_q, tog_d, zlp_q, zlp_d;
  assign len = (rem_q < 8'(MAXPKT)) ? rem_q[6:0] : MAXLEN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      rom_addr_q <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      pid_q      <= PID_DATA1;
      tog_q      <= 1'b1;
      zlp_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rom_addr_q <= rom_addr_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      pid_q      <= pid_d;
      tog_q      <= tog_d;
      zlp_q      <= zlp_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    rom_addr_d = rom_addr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    pid_d      = pid_q;
    tog_d      = tog_q;
    zlp_d      = zlp_q;
    case (state_q)
      WAIT_IN: if (in_token) begin
        cnt_d      = '0;
        rom_addr_d = base_q;
        state_d    = (len == 7'd0) ? SEND : RD;
      end
      RD: state_d = WR;
      WR: if (!full_tx) begin
        cnt_d      = cnt_q + 7'd1;
        rom_addr_d = base_q + ROM_AW'(cnt_d);
        state_d    = (cnt_d == len) ? SEND : RD;
      end
      SEND: state_d = WAIT_ACK;
      WAIT_ACK: if (ack_rcvd) begin
        base_d  = base_q + ROM_AW'(len);
        rem_d   = rem_q - 8'(len);
        tog_d   = ~tog_q;
        zlp_d   = (len == 7'd0) ? 1'b0 : (len == MAXLEN && rem_d == 8'd0) ? 1'b1 : zlp_q;
        state_d = (rem_d == 8'd0 && !zlp_d) ? DONE : WAIT_IN;
      end else if (in_token) begin
        cnt_d      = '0;
        rom_addr_d = base_q;
        state_d    = (len == 7'd0) ? SEND : RD;
      end
      default: ;
    endcase
    if (setup_done) begin
      base_d  = romaddr;
      rem_d   = romnum;
      tog_d   = 1'b1;
      zlp_d   = (romnum == 8'd0);
      state_d = WAIT_IN;
    end
    // PID and length are captured on entry to SEND so they hold until the next packet
    if (state_d == SEND) begin
      pid_d = tog_q ? PID_DATA1 : PID_DATA0;
      len_d = len;
    end
  end
  assign rom_addr = rom_addr_q;
  assign push_tx  = (state_q == WR) && !full_tx;
  assign datai_tx = push_tx ? rom_data : 8'd0;
  assign tx_start = (state_q == SEND);
  assign tx_pid   = pid_q;
  assign tx_len   = len_q;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
endmodule

// File: tb/tb_usb_ep0_in_tx.sv
// tb_usb_ep0_in_tx: directed and random EP0 IN transfers against a chunk-level reference model
module tb_usb_ep0_in_tx;
  logic clk = 0, rst = 1, setup_done = 0, in_token = 0, ack_rcvd = 0, full_tx = 0;
  logic [8:0] romaddr = '0;
  logic [7:0] romnum = '0;
  logic [8:0] rom_addr;
  logic [7:0] rom_data = '0, datai_tx;
  logic push_tx, tx_start, busy, done;
  logic [3:0] tx_pid;
  logic [6:0] tx_len;
  logic [7:0] rom [512];
  logic [7:0] q [$];
  int cyc = 0, tok_cyc = 0, start_cyc = 0, start_cnt = 0;
  logic [3:0] st_pid = '0;
  logic [6:0] st_len = '0;
  int passed = 0, total = 0;

  usb_ep0_in_tx #(.MAXPKT(64), .ROM_AW(9)) dut (
    .clk(clk), .rst(rst), .setup_done(setup_done), .romaddr(romaddr), .romnum(romnum),
    .in_token(in_token), .ack_rcvd(ack_rcvd), .rom_addr(rom_addr), .rom_data(rom_data),
    .push_tx(push_tx), .datai_tx(datai_tx), .full_tx(full_tx), .tx_start(tx_start),
    .tx_pid(tx_pid), .tx_len(tx_len), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(negedge clk) begin
    if (in_token) tok_cyc = cyc;
    if (push_tx) q.push_back(datai_tx);
    if (tx_start) begin
      start_cyc = cyc;
      st_pid = tx_pid;
      st_len = tx_len;
      start_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setup(input int a, input int n);
    tick(1);
    setup_done = 1; romaddr = 9'(a); romnum = 8'(n);
    tick(1);
    setup_done = 0;
    chk("busy_after_setup", busy, 1);
  endtask

  task automatic pulse_ack();
    ack_rcvd = 1;
    tick(1);
    ack_rcvd = 0;
  endtask

  // One IN token; expects n bytes from ROM[a..] with the given PID, optionally stalling 5 cycles at byte 10
  task automatic packet(input int a, input int n, input logic [3:0] pid, input bit stall);
    int qs = q.size(), s0 = start_cnt, lim = 0;
    in_token = 1;
    tick(1);
    in_token = 0;
    if (stall) begin
      tick(1 + 2 * 10);
      full_tx = 1;
      tick(5);
      full_tx = 0;
    end
    while (start_cnt == s0 && lim < 600) begin
      tick(1);
      lim++;
    end
    if (start_cnt == s0) begin
      chk("tx_start_timeout", 0, 1);
      return;
    end
    chk("latency", start_cyc - tok_cyc, 2 * n + 1 + (stall ? 5 : 0));
    chk("tx_pid", st_pid, pid);
    chk("tx_len", st_len, n);
    chk("byte_count", q.size() - qs, n);
    for (int i = 0; i < n && qs + i < q.size(); i++)
      chk($sformatf("byte%0d", i), q[qs + i], rom[(a + i) % 512]);
  endtask

  // Reference: a window of n bytes always yields n/64+1 packets, the last one short (possibly empty)
  task automatic transfer(input int a, input int n, input bit retx, input bit stall);
    setup(a, n);
    for (int p = 0; p <= n / 64; p++) begin
      int off = p * 64;
      int len = (n - off < 64) ? n - off : 64;
      logic [3:0] pid = (p % 2 == 0) ? 4'hB : 4'h3;
      packet((a + off) % 512, len, pid, stall && p == 0);
      if (retx && p == 0) packet((a + off) % 512, len, pid, 0);
      chk("busy_in_stage", busy, 1);
      pulse_ack();
      chk("pid_hold", tx_pid, pid);
    end
    chk("done", done, 1);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    int s0, qs;
    for (int i = 0; i < 512; i++) rom[i] = 8'($urandom);
    tick(3);
    rst = 0;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_push", push_tx, 0);
    chk("rst_datai", datai_tx, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_pid", tx_pid, 4'hB);
    chk("rst_tx_len", tx_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    in_token = 1;
    tick(1);
    in_token = 0;
    tick(4);
    chk("idle_ignores_in", start_cnt, 0);
    chk("idle_busy", busy, 0);
    transfer(0, 18, 0, 0);
    transfer(232, 109, 0, 0);
    transfer(100, 64, 0, 0);
    transfer(7, 0, 0, 0);
    transfer(300, 100, 1, 0);
    transfer(40, 30, 0, 1);
    s0 = start_cnt;
    in_token = 1;
    tick(1);
    in_token = 0;
    tick(5);
    chk("done_ignores_in", start_cnt, s0);
    chk("done_hold", done, 1);
    setup(16, 50);
    in_token = 1;
    tick(1);
    in_token = 0;
    tick(8);
    setup(88, 4);
    qs = q.size();
    s0 = start_cnt;
    tick(4);
    chk("abandon_no_push", q.size(), qs);
    chk("abandon_no_start", start_cnt, s0);
    packet(88, 4, 4'hB, 0);
    pulse_ack();
    chk("abandon_done", done, 1);
    for (int r = 0; r < 3; r++) transfer($urandom_range(0, 511), $urandom_range(0, 255), 0, 0);
    setup(0, 200);
    in_token = 1;
    tick(1);
    in_token = 0;
    tick(6);
    rst = 1;
    tick(1);
    rst = 0;
    @(negedge clk);
    chk("mid_rst_rom_addr", rom_addr, 0);
    chk("mid_rst_push", push_tx, 0);
    chk("mid_rst_datai", datai_tx, 0);
    chk("mid_rst_tx_start", tx_start, 0);
    chk("mid_rst_tx_pid", tx_pid, 4'hB);
    chk("mid_rst_tx_len", tx_len, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
